jalr_update_queue: RTL and testbench

Backend-side writer for the fetch-stage JALR target predictor. It takes up to three resolved control-flow results per cycle from the execute lanes and detects JALR target mispredictions. Pending table updates are buffered in a small coalescing queue and drained one per cycle onto one predictor update port, in the predictor's update format.

---
 rtl/jalr_update_queue.sv | 208 ++++++++++++++++++++
 tb/tb_jalr_update_queue.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/jalr_update_queue.sv
// jalr_update_queue: detects JALR target mispredictions on three execute lanes,
// buffers predictor updates in a small coalescing queue and drains one per
// cycle onto the fetch-stage JALR predictor update port.
module jalr_update_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid_0,
    input  logic                  res_is_jalr_0,
    input  logic [ADDR_WIDTH-1:0] res_pc_plus4_0,
    input  logic                  res_pred_valid_0,
    input  logic [ADDR_WIDTH-1:0] res_pred_target_0,
    input  logic [ADDR_WIDTH-1:0] res_actual_target_0,
    input  logic                  res_valid_1,
    input  logic                  res_is_jalr_1,
    input  logic [ADDR_WIDTH-1:0] res_pc_plus4_1,
    input  logic                  res_pred_valid_1,
    input  logic [ADDR_WIDTH-1:0] res_pred_target_1,
    input  logic [ADDR_WIDTH-1:0] res_actual_target_1,
    input  logic                  res_valid_2,
    input  logic                  res_is_jalr_2,
    input  logic [ADDR_WIDTH-1:0] res_pc_plus4_2,
    input  logic                  res_pred_valid_2,
    input  logic [ADDR_WIDTH-1:0] res_pred_target_2,
    input  logic [ADDR_WIDTH-1:0] res_actual_target_2,
    output logic [ADDR_WIDTH-1:0] upd_pc_o,
    output logic                  upd_branch_o,
    output logic                  upd_mispred_o,
    output logic [ADDR_WIDTH-1:0] upd_target_o,
    output logic                  queue_full_o,
    output logic [15:0]           mispred_cnt_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int NL    = 3;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // lane inputs gathered into arrays, lane 0 is the oldest
    logic [NL-1:0]                 ln_valid, ln_jalr, ln_pvalid;
    logic [NL-1:0][ADDR_WIDTH-1:0] ln_pc4, ln_pred, ln_act;
    logic [NL-1:0]                 ln_mp, ln_surv;
    logic [NL-1:0][INDEX_BITS-1:0] ln_idx;

    assign ln_valid  = {res_valid_2, res_valid_1, res_valid_0};
    assign ln_jalr   = {res_is_jalr_2, res_is_jalr_1, res_is_jalr_0};
    assign ln_pvalid = {res_pred_valid_2, res_pred_valid_1, res_pred_valid_0};
    assign ln_pc4    = {res_pc_plus4_2, res_pc_plus4_1, res_pc_plus4_0};
    assign ln_pred   = {res_pred_target_2, res_pred_target_1, res_pred_target_0};
    assign ln_act    = {res_actual_target_2, res_actual_target_1, res_actual_target_0};

    // queue storage and control state
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_pc_q, ent_pc_d;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_tgt_q, ent_tgt_d;
    logic [DEPTH-1:0][INDEX_BITS-1:0] ent_idx_q, ent_idx_d;
    logic [PTR_W-1:0]                 head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;

    // output registers
    logic [ADDR_WIDTH-1:0] upd_pc_q, upd_pc_d, upd_tgt_q, upd_tgt_d;
    logic                  upd_mispred_q, upd_mispred_d;
    logic                  queue_full_q, queue_full_d;
    logic [15:0]           mc_q, mc_d;
    logic [7:0]            dc_q, dc_d;

    // per-cycle working signals
    logic                        deq;
    logic [CNT_W-1:0]            avail;
    logic [DEPTH-1:0][PTR_W-1:0] slot_off;
    logic [DEPTH-1:0]            cand;
    logic                        hit;
    logic [PTR_W-1:0]            wptr;
    logic [CNT_W-1:0]            n_alloc;
    logic [1:0]                  n_drop;
    logic [1:0]                  n_mp;
    logic [16:0]                 mc_sum;
    logic [8:0]                  dc_sum;

    // misprediction detect; index is (pc_plus4 - 4)[INDEX_BITS+1:2], which
    // equals the pc_plus4 slice minus one since the low two bits never borrow
    always_comb begin
        ln_mp  = '0;
        ln_idx = '0;
        for (int k = 0; k < NL; k++) begin
            ln_mp[k]  = ln_valid[k] & ln_jalr[k] &
                        (~ln_pvalid[k] | (ln_pred[k] != ln_act[k]));
            ln_idx[k] = ln_pc4[k][INDEX_BITS+1:2] - INDEX_BITS'(1);
        end
    end

    // same-cycle coalescing: a younger lane with the same index wins
    always_comb begin
        ln_surv = ln_mp;
        for (int k = 0; k < NL; k++) begin
            for (int j = k + 1; j < NL; j++) begin
                if (ln_mp[j] && (ln_idx[j] == ln_idx[k])) ln_surv[k] = 1'b0;
            end
        end
    end

    // live entries that may absorb a new update; the head leaving this cycle
    // is excluded so its update is not silently lost
    always_comb begin
        deq      = (count_q != '0);
        avail    = CNT_W'(DEPTH) - count_q + {{(CNT_W-1){1'b0}}, deq};
        slot_off = '0;
        cand     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off[i] = PTR_W'(i) - head_q;
            cand[i]     = ({1'b0, slot_off[i]} < count_q) &&
                          !(deq && (head_q == PTR_W'(i)));
        end
    end

    // queue update: coalesce into matching entries, else allocate at the tail
    // in lane order until free slots run out, counting the overflow as drops
    always_comb begin
        ent_pc_d  = ent_pc_q;
        ent_tgt_d = ent_tgt_q;
        ent_idx_d = ent_idx_q;
        wptr      = tail_q;
        n_alloc   = '0;
        n_drop    = '0;
        hit       = 1'b0;
        for (int k = 0; k < NL; k++) begin
            hit = 1'b0;
            if (ln_surv[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!hit && cand[i] && (ent_idx_q[i] == ln_idx[k])) begin
                        hit          = 1'b1;
                        ent_pc_d[i]  = ln_pc4[k];
                        ent_tgt_d[i] = ln_act[k];
                    end
                end
                if (!hit) begin
                    if (n_alloc < avail) begin
                        ent_pc_d[wptr]  = ln_pc4[k];
                        ent_tgt_d[wptr] = ln_act[k];
                        ent_idx_d[wptr] = ln_idx[k];
                        wptr            = wptr + PTR_W'(1);
                        n_alloc         = n_alloc + CNT_W'(1);
                    end else begin
                        n_drop = n_drop + 2'd1;
                    end
                end
            end
        end
        tail_d  = wptr;
        head_d  = head_q + (deq ? PTR_W'(1) : PTR_W'(0));
        count_d = count_q - {{(CNT_W-1){1'b0}}, deq} + n_alloc;
    end

    // output staging and saturating counters
    always_comb begin
        upd_mispred_d = deq;
        upd_pc_d      = deq ? ent_pc_q[head_q]  : upd_pc_q;
        upd_tgt_d     = deq ? ent_tgt_q[head_q] : upd_tgt_q;
        queue_full_d  = (count_d == CNT_W'(DEPTH));
        n_mp          = {1'b0, ln_mp[0]} + {1'b0, ln_mp[1]} + {1'b0, ln_mp[2]};
        mc_sum        = {1'b0, mc_q} + {15'd0, n_mp};
        mc_d          = mc_sum[16] ? 16'hFFFF : mc_sum[15:0];
        dc_sum        = {1'b0, dc_q} + {7'd0, n_drop};
        dc_d          = dc_sum[8] ? 8'hFF : dc_sum[7:0];
    end

    // state registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_pc_q      <= '0;
            ent_tgt_q     <= '0;
            ent_idx_q     <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            upd_pc_q      <= '0;
            upd_tgt_q     <= '0;
            upd_mispred_q <= 1'b0;
            queue_full_q  <= 1'b0;
            mc_q          <= '0;
            dc_q          <= '0;
        end else begin
            ent_pc_q      <= ent_pc_d;
            ent_tgt_q     <= ent_tgt_d;
            ent_idx_q     <= ent_idx_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            upd_pc_q      <= upd_pc_d;
            upd_tgt_q     <= upd_tgt_d;
            upd_mispred_q <= upd_mispred_d;
            queue_full_q  <= queue_full_d;
            mc_q          <= mc_d;
            dc_q          <= dc_d;
        end
    end

    assign upd_pc_o      = upd_pc_q;
    assign upd_target_o  = upd_tgt_q;
    assign upd_mispred_o = upd_mispred_q;
    assign upd_branch_o  = 1'b0;
    assign queue_full_o  = queue_full_q;
    assign mispred_cnt_o = mc_q;
    assign drop_cnt_o    = dc_q;

endmodule

// File: tb/tb_jalr_update_queue.sv
// Directed-vector bench for jalr_update_queue.
module tb_jalr_update_queue;

    typedef struct packed {
        logic        v;
        logic        j;
        logic        pv;
        logic [31:0] pc;
        logic [31:0] pt;
        logic [31:0] at;
    } lane_t;

    typedef struct packed {
        lane_t       l0;
        lane_t       l1;
        lane_t       l2;
        logic        mp;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        full;
        logic [15:0] mc;
        logic [7:0]  dc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    lane_t       la0, la1, la2;
    logic [31:0] upd_pc_o, upd_target_o;
    logic        upd_branch_o, upd_mispred_o, queue_full_o;
    logic [15:0] mispred_cnt_o;
    logic [7:0]  drop_cnt_o;

    int checks = 0;
    int errors = 0;
    vec_t tv[18];

    always #5 clk = ~clk;

    jalr_update_queue #(.ADDR_WIDTH(32), .DEPTH(4), .INDEX_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .res_valid_0(la0.v), .res_is_jalr_0(la0.j), .res_pc_plus4_0(la0.pc),
        .res_pred_valid_0(la0.pv), .res_pred_target_0(la0.pt), .res_actual_target_0(la0.at),
        .res_valid_1(la1.v), .res_is_jalr_1(la1.j), .res_pc_plus4_1(la1.pc),
        .res_pred_valid_1(la1.pv), .res_pred_target_1(la1.pt), .res_actual_target_1(la1.at),
        .res_valid_2(la2.v), .res_is_jalr_2(la2.j), .res_pc_plus4_2(la2.pc),
        .res_pred_valid_2(la2.pv), .res_pred_target_2(la2.pt), .res_actual_target_2(la2.at),
        .upd_pc_o(upd_pc_o), .upd_branch_o(upd_branch_o), .upd_mispred_o(upd_mispred_o),
        .upd_target_o(upd_target_o), .queue_full_o(queue_full_o),
        .mispred_cnt_o(mispred_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    function automatic lane_t jl(input logic [31:0] pc4, input logic [31:0] at);
        jl = '{v: 1'b1, j: 1'b1, pv: 1'b0, pc: pc4, pt: 32'h0, at: at};
    endfunction

    function automatic vec_t mkv(input lane_t l0, input lane_t l1, input lane_t l2,
                                 input logic mp, input logic [31:0] pc,
                                 input logic [31:0] tgt, input logic full,
                                 input logic [15:0] mc, input logic [7:0] dc);
        mkv = '{l0: l0, l1: l1, l2: l2, mp: mp, pc: pc, tgt: tgt,
                full: full, mc: mc, dc: dc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic mp, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic full,
                           input logic [15:0] mc, input logic [7:0] dc);
        chk({tag, " mispred"}, {31'd0, upd_mispred_o}, {31'd0, mp});
        chk({tag, " pc"},      upd_pc_o, pc);
        chk({tag, " target"},  upd_target_o, tgt);
        chk({tag, " full"},    {31'd0, queue_full_o}, {31'd0, full});
        chk({tag, " mcnt"},    {16'd0, mispred_cnt_o}, {16'd0, mc});
        chk({tag, " dcnt"},    {24'd0, drop_cnt_o}, {24'd0, dc});
        chk({tag, " branch"},  {31'd0, upd_branch_o}, 32'd0);
    endtask

    task automatic run_vec(input int i);
        la0 = tv[i].l0;
        la1 = tv[i].l1;
        la2 = tv[i].l2;
        @(posedge clk);
        #1;
        chk_all($sformatf("vec%0d", i), tv[i].mp, tv[i].pc, tv[i].tgt,
                tv[i].full, tv[i].mc, tv[i].dc);
    endtask

    initial begin
        lane_t nop, ok;
        nop = '0;
        ok  = '{v: 1'b1, j: 1'b1, pv: 1'b1, pc: 32'h204, pt: 32'h3000, at: 32'h3000};

        // single miss, latency, correct prediction, same-cycle coalescing
        tv[0]  = mkv(nop, jl(32'h104, 32'h2000), nop, 0, 32'h0,   32'h0,    0, 1, 0);
        tv[1]  = mkv(nop, nop, nop,                   1, 32'h104, 32'h2000, 0, 1, 0);
        tv[2]  = mkv(ok,  nop, nop,                   0, 32'h104, 32'h2000, 0, 1, 0);
        tv[3]  = mkv(jl(32'h104, 32'hA0), nop, jl(32'h144, 32'hB0),
                                                      0, 32'h104, 32'h2000, 0, 3, 0);
        tv[4]  = mkv(nop, nop, nop,                   1, 32'h144, 32'hB0,   0, 3, 0);
        tv[5]  = mkv(nop, nop, nop,                   0, 32'h144, 32'hB0,   0, 3, 0);
        // queue coalescing into the non-head index-5 entry
        tv[6]  = mkv(jl(32'h8, 32'h100), jl(32'h18, 32'h200), nop,
                                                      0, 32'h144, 32'hB0,   0, 5, 0);
        tv[7]  = mkv(jl(32'h58, 32'hC0), nop, nop,    1, 32'h8,   32'h100,  0, 6, 0);
        tv[8]  = mkv(nop, nop, nop,                   1, 32'h58,  32'hC0,   0, 6, 0);
        tv[9]  = mkv(nop, nop, nop,                   0, 32'h58,  32'hC0,   0, 6, 0);
        // fill to 3, then overflow with a dequeue in flight
        tv[10] = mkv(jl(32'h8, 32'h11), jl(32'hC, 32'h22), jl(32'h10, 32'h33),
                                                      0, 32'h58,  32'hC0,   0, 9, 0);
        tv[11] = mkv(jl(32'h14, 32'h40), jl(32'h1C, 32'h60), jl(32'h20, 32'h70),
                                                      1, 32'h8,   32'h11,   1, 12, 1);
        tv[12] = mkv(nop, nop, nop,                   1, 32'hC,   32'h22,   0, 12, 1);
        // after reset: 3-deep burst, one strobe per cycle; non-JALR lane ignored
        tv[13] = mkv(jl(32'h8, 32'h11), jl(32'hC, 32'h22), jl(32'h10, 32'h33),
                                                      0, 32'h0,   32'h0,    0, 3, 0);
        tv[14] = mkv(nop, nop, nop,                   1, 32'h8,   32'h11,   0, 3, 0);
        tv[15] = mkv('{v: 1'b1, j: 1'b0, pv: 1'b0, pc: 32'h30, pt: 32'h0, at: 32'h99},
                     nop, nop,                        1, 32'hC,   32'h22,   0, 3, 0);
        tv[16] = mkv(nop, nop, nop,                   1, 32'h10,  32'h33,   0, 3, 0);
        tv[17] = mkv(nop, nop, nop,                   0, 32'h10,  32'h33,   0, 3, 0);

        la0 = nop; la1 = nop; la2 = nop;
        reset = 1'b0;
        #2;
        chk_all("reset", 0, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i <= 12; i++) run_vec(i);

        // asynchronous reset with 3 updates pending
        la0 = nop; la1 = nop; la2 = nop;
        #2;
        reset = 1'b0;
        #1;
        chk_all("midreset", 0, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("postreset%0d", c), 0, 32'h0, 32'h0, 0, 0, 0);
        end

        for (int i = 13; i <= 17; i++) run_vec(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
